id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 id_valid  input  1  decode slot holds a real instruction.
REQ-004 id_ctrl  input  ctrl_t  decoded control bundle: alu_control[2:0], reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch.
REQ-005 id_pc  input  64  PC of decoded instruction.
REQ-006 id_rs1_data, id_rs2_data  input  64 each  register-file read data.
REQ-007 id_imm  input  64  sign-extended immediate.
REQ-008 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-009 id_uses_rs2  input  1  instruction reads rs2 (R, S, B types).
REQ-010 flush  input  1  taken branch resolved downstream; kill decode slot.
REQ-011 ex_valid  output  1  EX slot holds a real instruction.
REQ-012 ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd  output  widths as inputs  registered copies.
REQ-013 stall  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-014 bubble_count  output  16  count of bubbles inserted by load-use stalls.

Function
REQ-015 Normal cycle (no flush, no stall): all ex_* outputs SHALL capture id_* inputs on the next rising clk; latency exactly 1 cycle.
REQ-016 Load-use hazard SHALL be detected when ex_valid=1, ex_ctrl.mem_read=1, ex_rd!=0, id_valid=1, and (ex_rd==id_rs1 or (id_uses_rs2=1 and ex_rd==id_rs2)).
REQ-017 On hazard, stall SHALL be 1 in that cycle and the EX slot SHALL load a bubble: ex_valid=0, ex_ctrl all zero with alu_control=ALU_ADD; data fields don't-care but held at previous value.
REQ-018 Stall SHALL last exactly one cycle per hazard; next cycle the held instruction re-evaluates against the bubble and proceeds.
REQ-019 flush=1 SHALL load a bubble into EX and force stall=0, taking priority over a simultaneous hazard.
REQ-020 Bubbles (hazard or flush) SHALL never assert reg_write, mem_read, mem_write or branch at ex_ctrl.
REQ-021 id_valid=0 SHALL load a bubble; no hazard may be raised for an invalid decode slot.
REQ-022 bubble_count SHALL increment by 1 for each hazard bubble (not flush bubbles), saturating at 16'hFFFF.
REQ-023 x0 as destination SHALL never cause a stall.

Reset
REQ-024 While rst=1, ex_valid=0, ex_ctrl zero with alu_control=ALU_ADD, all data/index outputs 0, bubble_count=0, stall=0.
REQ-025 Reset asserted mid-stall SHALL discard the held hazard; first post-reset cycle behaves as REQ-015.

Configuration
REQ-026 Macro HAZARD_DETECT_EN: defined -> REQ-016..018, REQ-022 active; undefined -> stall tied 0, bubble_count tied 0, hazard logic absent, flush and id_valid bubbles unchanged.

Structure
REQ-027 ctrl_t packed struct, ALU_* codes, opcode constants and XLEN=64 SHALL live in shared package pipeline_pkg, also used by the decoder.
REQ-028 Load-use detection SHALL be a combinational sub-module hazard_detect; state (EX register, counter) stays in id_ex_stage.

Verification
REQ-029 ADDI x5,x0,7 decoded with id_valid=1 -> next cycle ex_valid=1, ex_ctrl.reg_write=1, alu_src=1, ex_imm=7, ex_rd=5.
REQ-030 LD x6 in EX, ADD x7,x6,x1 in ID -> stall=1 one cycle, ex_valid=0 next cycle, then ADD enters EX; bubble_count=1.
REQ-031 LD x6 in EX, ADDI x7,x0,3 (id_rs2=6, id_uses_rs2=0) in ID -> stall=0, no bubble.
REQ-032 Hazard and flush=1 same cycle -> stall=0, ex_valid=0, bubble_count unchanged.
REQ-033 LD x0 in EX, ADD x1,x0,x0 in ID -> stall=0.
REQ-034 rst pulsed during stall cycle -> all outputs zero immediately; after release, SD enters EX with mem_write=1 one cycle later.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: XLEN, ALU codes, opcodes and the decoded control bundle.
// Used by the decoder and by the ID/EX stage.
package pipeline_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
  } ctrl_t;

  // A bubble must not touch architectural state; the ALU still sees a harmless ADD.
  localparam ctrl_t CTRL_BUBBLE = '{
    alu_control: ALU_ADD,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    mem_to_reg:  1'b0,
    alu_src:     1'b0,
    branch:      1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector comparing the load in EX against the
// source registers of the instruction sitting in decode.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  output logic       load_use
);

  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load targeting it never produces a dependency.
  assign rs1_match = (ex_rd == id_rs1);
  assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
  assign load_use  = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid
                     && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion for flush, invalid slots and
// load-use stalls. Load-use detection is built only when HAZARD_DETECT_EN is defined.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  ctrl_t           id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs2,
  input  logic            flush,
  output logic            ex_valid,
  output ctrl_t           ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            stall,
  output logic [15:0]     bubble_count
);

  logic load_bubble;

`ifdef HAZARD_DETECT_EN
  logic load_use;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  // A flush kills the decode slot, so holding it for a hazard would be pointless.
  assign stall = load_use && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= 16'h0000;
    end else if (stall && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'h0001;
    end
  end
`else
  logic unused_uses_rs2;

  assign unused_uses_rs2 = id_uses_rs2;
  assign stall           = 1'b0;
  assign bubble_count    = 16'h0000;
`endif

  assign load_bubble = flush || stall || !id_valid;

  // Bubbles only rewrite valid and control; data fields keep their old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
    end else if (load_bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_BUBBLE;
    end else begin
      ex_valid    <= 1'b1;
      ex_ctrl     <= id_ctrl;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow HAZARD_DETECT_EN when defined.
module tb_id_ex_stage;
  import pipeline_pkg::*;

`ifdef HAZARD_DETECT_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] cnt;
  } ex_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses2;
    logic        flush;
  } stim_t;

  localparam ctrl_t C_LD   = '{alu_control: ALU_ADD, reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1, alu_src: 1'b1, branch: 1'b0};
  localparam ctrl_t C_ADD  = '{alu_control: ALU_ADD, reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b0, branch: 1'b0};
  localparam ctrl_t C_ADDI = '{alu_control: ALU_ADD, reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b1, branch: 1'b0};
  localparam ctrl_t C_SD   = '{alu_control: ALU_ADD, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0, alu_src: 1'b1, branch: 1'b0};
  localparam ctrl_t C_BEQ  = '{alu_control: ALU_SUB, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b0, branch: 1'b1};

  logic        clk;
  logic        rst;
  logic        id_valid;
  ctrl_t       id_ctrl;
  logic [63:0] id_pc;
  logic [63:0] id_rs1_data;
  logic [63:0] id_rs2_data;
  logic [63:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs2;
  logic        flush;
  logic        ex_valid;
  ctrl_t       ex_ctrl;
  logic [63:0] ex_pc;
  logic [63:0] ex_rs1_data;
  logic [63:0] ex_rs2_data;
  logic [63:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        stall;
  logic [15:0] bubble_count;

  int   checks;
  int   errors;
  ex_t  m;
  ex_t  sb[$];

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ctrl      (id_ctrl),
    .id_pc        (id_pc),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_uses_rs2  (id_uses_rs2),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ctrl      (ex_ctrl),
    .ex_pc        (ex_pc),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .bubble_count (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t dut_state();
    return {ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, bubble_count};
  endfunction

  function automatic ex_t reset_state();
    ex_t z;
    z      = '0;
    z.ctrl = CTRL_BUBBLE;
    return z;
  endfunction

  function automatic stim_t mk(input logic v, input ctrl_t c, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u, input logic [63:0] imm, input logic fl);
    stim_t s;
    s.valid = v;
    s.ctrl  = c;
    s.pc    = {32'h0, $urandom} & 64'hFFFF_FFFC;
    s.rs1d  = {$urandom, $urandom};
    s.rs2d  = {$urandom, $urandom};
    s.imm   = imm;
    s.rs1   = rs1;
    s.rs2   = rs2;
    s.rd    = rd;
    s.uses2 = u;
    s.flush = fl;
    return s;
  endfunction

  task automatic model_reset();
    m = reset_state();
    sb.delete();
  endtask

  // Drive one decode slot at the falling edge and push the EX state it should produce.
  task automatic issue(input stim_t s, output logic exp_st);
    logic hz;
    @(negedge clk);
    id_valid    = s.valid;
    id_ctrl     = s.ctrl;
    id_pc       = s.pc;
    id_rs1_data = s.rs1d;
    id_rs2_data = s.rs2d;
    id_imm      = s.imm;
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_rd       = s.rd;
    id_uses_rs2 = s.uses2;
    flush       = s.flush;
    #1;
    hz = 1'b0;
    if (HZ)
      hz = m.valid && m.ctrl.mem_read && (m.rd != 5'd0) && s.valid &&
           ((m.rd == s.rs1) || (s.uses2 && (m.rd == s.rs2)));
    exp_st = hz && !s.flush;
    if (s.flush || exp_st || !s.valid) begin
      m.valid = 1'b0;
      m.ctrl  = CTRL_BUBBLE;
      if (exp_st && (m.cnt != 16'hFFFF)) m.cnt = m.cnt + 16'd1;
    end else begin
      m.valid = 1'b1;
      m.ctrl  = s.ctrl;
      m.pc    = s.pc;
      m.rs1d  = s.rs1d;
      m.rs2d  = s.rs2d;
      m.imm   = s.imm;
      m.rs1   = s.rs1;
      m.rs2   = s.rs2;
      m.rd    = s.rd;
    end
    sb.push_back(m);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ex_t got;
    rst = 1'b1;
    id_valid = 1'b1; id_ctrl = C_LD; id_pc = 64'h1234; id_rs1_data = 64'h55;
    id_rs2_data = 64'h66; id_imm = 64'h8; id_rs1 = 5'd6; id_rs2 = 5'd6; id_rd = 5'd6;
    id_uses_rs2 = 1'b1; flush = 1'b0;
    repeat (2) advance();
    model_reset();
    got = dut_state();
    checks++;
    if (got !== reset_state()) begin
      errors++; $display("[TB] FAIL reset_state got %h exp %h", got, reset_state());
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stall got %b exp 0", stall);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_addi();
    logic es;
    ex_t  e, g;
    issue(mk(1'b1, C_ADDI, 5'd0, 5'd7, 5'd5, 1'b0, 64'd7, 1'b0), es);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL addi_stall got %b exp 0", stall); end
    advance();
    e = sb.pop_front(); g = dut_state();
    checks++;
    if (g !== e) begin errors++; $display("[TB] FAIL addi_state got %h exp %h", g, e); end
    checks++;
    if ({ex_valid, ex_ctrl.reg_write, ex_ctrl.alu_src, ex_imm, ex_rd} !== {1'b1, 1'b1, 1'b1, 64'd7, 5'd5}) begin
      errors++; $display("[TB] FAIL addi_fields got v%b rw%b as%b imm%0d rd%0d exp v1 rw1 as1 imm7 rd5",
                         ex_valid, ex_ctrl.reg_write, ex_ctrl.alu_src, ex_imm, ex_rd);
    end
  endtask

  task automatic test_load_use();
    stim_t      seq[$];
    logic       exp_stall[$];
    logic       es;
    ex_t        e, g;
    logic [15:0] cnt0;
    cnt0 = m.cnt;
    seq.push_back(mk(1'b1, C_LD, 5'd2, 5'd0, 5'd6, 1'b0, 64'd16, 1'b0)); exp_stall.push_back(1'b0);
    seq.push_back(mk(1'b1, C_ADD, 5'd6, 5'd1, 5'd7, 1'b1, 64'd0, 1'b0)); exp_stall.push_back(HZ);
    if (HZ) begin
      seq.push_back(seq[1]); exp_stall.push_back(1'b0);
    end
    foreach (seq[i]) begin
      issue(seq[i], es);
      checks++;
      if (stall !== exp_stall[i]) begin
        errors++; $display("[TB] FAIL load_use_stall[%0d] got %b exp %b", i, stall, exp_stall[i]);
      end
      advance();
      e = sb.pop_front(); g = dut_state();
      checks++;
      if (g !== e) begin errors++; $display("[TB] FAIL load_use_state[%0d] got %h exp %h", i, g, e); end
    end
    checks++;
    if ({ex_valid, ex_rd, bubble_count} !== {1'b1, 5'd7, cnt0 + {15'd0, HZ}}) begin
      errors++; $display("[TB] FAIL load_use_final got v%b rd%0d cnt%0d exp v1 rd7 cnt%0d",
                         ex_valid, ex_rd, bubble_count, cnt0 + {15'd0, HZ});
    end
  endtask

  // Hazard candidates that must not stall: unused rs2, x0 destination, invalid slot.
  task automatic test_no_stall_cases();
    stim_t seq[$];
    logic  es;
    ex_t   e, g;
    seq.push_back(mk(1'b1, C_LD,   5'd2, 5'd0, 5'd6, 1'b0, 64'd0, 1'b0));
    seq.push_back(mk(1'b1, C_ADDI, 5'd0, 5'd6, 5'd7, 1'b0, 64'd3, 1'b0));
    seq.push_back(mk(1'b1, C_LD,   5'd2, 5'd0, 5'd0, 1'b0, 64'd8, 1'b0));
    seq.push_back(mk(1'b1, C_ADD,  5'd0, 5'd0, 5'd1, 1'b1, 64'd0, 1'b0));
    seq.push_back(mk(1'b1, C_LD,   5'd2, 5'd0, 5'd6, 1'b0, 64'd0, 1'b0));
    seq.push_back(mk(1'b0, C_ADD,  5'd6, 5'd6, 5'd9, 1'b1, 64'd0, 1'b0));
    foreach (seq[i]) begin
      issue(seq[i], es);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("[TB] FAIL no_stall[%0d] got %b exp 0", i, stall); end
      advance();
      e = sb.pop_front(); g = dut_state();
      checks++;
      if (g !== e) begin errors++; $display("[TB] FAIL no_stall_state[%0d] got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_flush();
    logic        es;
    ex_t         e, g;
    logic [15:0] cnt0;
    issue(mk(1'b1, C_LD, 5'd2, 5'd0, 5'd6, 1'b0, 64'd0, 1'b0), es);
    advance();
    e = sb.pop_front(); g = dut_state();
    checks++;
    if (g !== e) begin errors++; $display("[TB] FAIL flush_load got %h exp %h", g, e); end
    cnt0 = bubble_count;
    issue(mk(1'b1, C_ADD, 5'd6, 5'd1, 5'd7, 1'b1, 64'd0, 1'b1), es);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got %b exp 0", stall); end
    advance();
    e = sb.pop_front(); g = dut_state();
    checks++;
    if (g !== e) begin errors++; $display("[TB] FAIL flush_state got %h exp %h", g, e); end
    checks++;
    if ({ex_valid, ex_ctrl, bubble_count} !== {1'b0, CTRL_BUBBLE, cnt0}) begin
      errors++; $display("[TB] FAIL flush_bubble got v%b ctrl%h cnt%0d exp v0 ctrl%h cnt%0d",
                         ex_valid, ex_ctrl, bubble_count, CTRL_BUBBLE, cnt0);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic es;
    ex_t  e, g;
    issue(mk(1'b1, C_LD, 5'd2, 5'd0, 5'd6, 1'b0, 64'd0, 1'b0), es);
    advance();
    e = sb.pop_front(); g = dut_state();
    checks++;
    if (g !== e) begin errors++; $display("[TB] FAIL rst_stall_load got %h exp %h", g, e); end
    issue(mk(1'b1, C_ADD, 5'd6, 5'd1, 5'd7, 1'b1, 64'd0, 1'b0), es);
    checks++;
    if (stall !== HZ) begin errors++; $display("[TB] FAIL rst_stall_pre got %b exp %b", stall, HZ); end
    #1 rst = 1'b1;
    #1;
    model_reset();
    g = dut_state();
    checks++;
    if ({g, stall} !== {reset_state(), 1'b0}) begin
      errors++; $display("[TB] FAIL rst_stall_clear got %h/%b exp %h/0", g, stall, reset_state());
    end
    @(negedge clk);
    rst = 1'b0;
    issue(mk(1'b1, C_SD, 5'd2, 5'd6, 5'd0, 1'b1, 64'd24, 1'b0), es);
    advance();
    e = sb.pop_front(); g = dut_state();
    checks++;
    if (g !== e) begin errors++; $display("[TB] FAIL rst_stall_sd got %h exp %h", g, e); end
    checks++;
    if ({ex_valid, ex_ctrl.mem_write} !== 2'b11) begin
      errors++; $display("[TB] FAIL rst_stall_sd_fields got v%b mw%b exp v1 mw1", ex_valid, ex_ctrl.mem_write);
    end
  endtask

  task automatic test_back_to_back();
    ctrl_t ctab[5];
    stim_t s;
    logic  es;
    ex_t   e, g;
    ctab[0] = C_LD; ctab[1] = C_ADD; ctab[2] = C_ADDI; ctab[3] = C_SD; ctab[4] = C_BEQ;
    for (int i = 0; i < 80; i++) begin
      s = mk(($urandom_range(0, 99) < 85), ctab[$urandom_range(0, 4)],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 99) < 10));
      issue(s, es);
      checks++;
      if (stall !== es) begin errors++; $display("[TB] FAIL b2b_stall[%0d] got %b exp %b", i, stall, es); end
      advance();
      e = sb.pop_front(); g = dut_state();
      checks++;
      if (g !== e) begin errors++; $display("[TB] FAIL b2b_state[%0d] got %h exp %h", i, g, e); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_addi();
    test_load_use();
    test_no_stall_cases();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
